// File: rtl/avalon_pio_gen2.sv
// Avalon-MM parallel I/O port with synchronized inputs, edge capture and a masked level interrupt.
// Optional macro AVALON_PIO_BITSET_EN adds OUTSET (addr 4) / OUTCLEAR (addr 5) write ports.
module avalon_pio_gen2 #(
  parameter int unsigned      WIDTH       = 18,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      EDGE_TYPE   = 0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [2:0]       i_address,
  input  logic             i_chipselect,
  input  logic             i_write_n,
  input  logic             i_read_n,
  input  logic [31:0]      i_writedata,
  output logic [31:0]      o_readdata,
  input  logic [WIDTH-1:0] i_in_port,
  output logic [WIDTH-1:0] o_out_port,
  output logic             o_irq
);

  logic [WIDTH-1:0] r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] r_out, r_mask, r_cap;
  logic [31:0]      r_readdata;

  logic             w_write, w_read;
  logic [WIDTH-1:0] w_wdata, w_edge, w_capClear, w_capNext, w_outNext;
  logic [31:0]      w_rdSel;
  logic             w_unused;

  assign w_write  = i_chipselect && !i_write_n;
  assign w_read   = i_chipselect && !i_read_n;
  assign w_wdata  = i_writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, i_writedata};

  always_comb begin
    w_edge = '0;
    case (EDGE_TYPE)
      0:       w_edge = r_s2 & ~r_s3;
      1:       w_edge = ~r_s2 & r_s3;
      default: w_edge = r_s2 ^ r_s3;
    endcase
  end

  // A new edge wins over a simultaneous write-1-to-clear on the same bit.
  assign w_capClear = (w_write && i_address == 3'd2) ? w_wdata : '0;
  assign w_capNext  = (r_cap & ~w_capClear) | w_edge;

  always_comb begin
    w_outNext = r_out;
    if (w_write) begin
      case (i_address)
        3'd0: w_outNext = w_wdata;
`ifdef AVALON_PIO_BITSET_EN
        3'd4: w_outNext = r_out | w_wdata;
        3'd5: w_outNext = r_out & ~w_wdata;
`endif
        default: w_outNext = r_out;
      endcase
    end
  end

  always_comb begin
    w_rdSel = '0;
    case (i_address)
      3'd0:    w_rdSel[WIDTH-1:0] = r_s2;
      3'd1:    w_rdSel[WIDTH-1:0] = r_mask;
      3'd2:    w_rdSel[WIDTH-1:0] = r_cap;
      3'd3:    w_rdSel[WIDTH-1:0] = r_out;
      default: w_rdSel = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_s3       <= '0;
      r_out      <= RESET_VALUE;
      r_mask     <= '0;
      r_cap      <= '0;
      r_readdata <= '0;
    end else begin
      r_s1  <= i_in_port;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_out <= w_outNext;
      r_cap <= w_capNext;
      if (w_write && i_address == 3'd1) begin
        r_mask <= w_wdata;
      end
      if (w_read) begin
        r_readdata <= w_rdSel;
      end
    end
  end

  assign o_readdata = r_readdata;
  assign o_out_port = r_out;
  assign o_irq      = |(r_cap & r_mask);

endmodule

// File: doc/avalon_pio_gen2.md
AVALON_PIO_GEN2 -- requirements
Module: avalon_pio_gen2

Interface
REQ-001 Parameter WIDTH, default 18, port bit width, legal range 1..32.
REQ-002 Parameter RESET_VALUE, default 0, out_port value after reset, WIDTH bits.
REQ-003 Parameter EDGE_TYPE, default 0, edge-capture mode: 0 = rising, 1 = falling, 2 = any.
REQ-004 clk  in  1  the single clock; all logic on its rising edge.
REQ-005 reset  in  1  reset, synchronous and active-high.
REQ-006 address  in  3  Avalon-MM word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  write strobe, active-low; a write is chipselect && !write_n.
REQ-009 read_n  in  1  read strobe, active-low; a read is chipselect && !read_n.
REQ-010 writedata  in  32  write data; bits above WIDTH-1 are ignored.
REQ-011 readdata  out  32  registered read data; bits above WIDTH-1 read 0.
REQ-012 in_port  in  WIDTH  asynchronous general-purpose inputs.
REQ-013 out_port  out  WIDTH  registered outputs.
REQ-014 irq  out  1  level interrupt, active-high.

Function
REQ-015 Register map:
- 0 DATA: W sets out_port; R returns the synchronized input.
- 1 IRQMASK: R/W.
- 2 EDGECAP: R; W1C.
- 3 OUTREAD: R returns out_port; writes are ignored.
- 4 OUTSET, 5 OUTCLEAR: see the Configuration section.
- 6, 7: read 0; writes are ignored.
REQ-016 in_port shall pass through a two-flop synchronizer (s1, s2), plus a third flop s3 that holds the previous s2 value.
REQ-017 DATA read shall return s2.
REQ-018 Edge detection per bit:
- rising: s2 & ~s3.
- falling: ~s2 & s3.
- any: s2 ^ s3.
REQ-019 A detected edge shall set its EDGECAP bit on the next clock.
REQ-020 A write of 1 to an EDGECAP bit shall clear it; a write of 0 leaves it unchanged.
REQ-021 If a clear and a new edge on the same bit occur in the same cycle, the bit shall end set.
REQ-022 irq shall be the combinational OR-reduce of (EDGECAP & IRQMASK), with no extra register stage.
REQ-023 readdata shall update on the clock edge that samples a read (latency 1); it shall hold its value when there is no read.
REQ-024 A read of EDGECAP shall not clear it.
REQ-025 A write to DATA shall update out_port on the next clock edge; out_port shall never glitch between writes.
REQ-026 With no write in flight, the input-to-EDGECAP-set latency shall be 3 clocks.

Reset
REQ-027 On a clock edge with reset=1, registers shall take these values: out_port = RESET_VALUE; IRQMASK = 0; EDGECAP = 0; s1, s2 and s3 = 0; readdata = 0.
REQ-028 Reset shall override any simultaneous bus access or edge.
REQ-029 An in_port bit held high through reset shall produce a rising edge 3 clocks after reset deasserts (EDGE_TYPE 0/2); this is the required behaviour.
REQ-030 Reset asserted mid-operation shall discard pending captures; irq shall be 0 in the cycle after the reset edge.

Configuration
REQ-031 Macro AVALON_PIO_BITSET_EN defined:
- a write to address 4 shall set out_port |= writedata.
- a write to address 5 shall clear out_port &= ~writedata.
- reads of 4 and 5 return 0.
- only one write can occur per cycle, so no conflict handling is required.
REQ-032 Macro AVALON_PIO_BITSET_EN undefined: addresses 4 and 5 behave as reserved (read 0, writes ignored), and the set/clear logic shall not be synthesized.

Verification
REQ-033 Reset test, WIDTH=18, RESET_VALUE=0x2A5A5: release reset -> out_port=0x2A5A5, irq=0, readdata=0.
REQ-034 DATA test: write DATA=0xFFFFFFFF -> out_port=0x3FFFF next clock; then read OUTREAD -> readdata=0x0003FFFF one clock after the read.
REQ-035 Edge capture test, EDGE_TYPE=0, IRQMASK=0x1:
- drive in_port bit0 0->1 -> EDGECAP=0x1 and irq=1 exactly 3 clocks later.
- write 0x1 to EDGECAP -> irq=0.
REQ-036 Clear/edge collision test: schedule a W1C of bit3 on the same clock that a bit-3 edge sets -> EDGECAP bit3 stays 1.
REQ-037 Bit set/clear test, with AVALON_PIO_BITSET_EN: out_port=0x00F0; write OUTSET=0x0003 -> 0x00F3; write OUTCLEAR=0x0030 -> 0x00C3. Without the macro, the same writes leave out_port at 0x00F0.
REQ-038 Reset mid-capture test: assert reset while EDGECAP=0x5 and irq=1 -> next clock EDGECAP=0 and irq=0.
